// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receive deframer, transmitter and command FSM.
// The optional parity stage is compiled in with the UART_RX_PARITY_EN macro.
package uart_pkg;

  // Default line rate: 50 MHz system clock at 115200 baud.
  localparam int UART_BR_DEFAULT         = 434;
  localparam int UART_DATA_WIDTH_DEFAULT = 8;

  // Receive FSM state encoding.
  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  // Width of an index over n items. It never returns 0, so a 1-bit frame still gets a legal vector.
  function automatic int uart_idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter shared by the UART receive and transmit paths.
// It counts 0..BR-1 and wraps. It provides a mid-bit strobe and an end-of-bit strobe.
// A synchronous clear realigns the count to 0.
module uart_baud_cnt #(
  parameter int BR = 434
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  output logic o_mid,
  output logic o_end
);

  localparam int CW = $clog2(BR);
  localparam logic [CW-1:0] LAST = CW'(BR - 1);
  localparam logic [CW-1:0] MID  = CW'(BR / 2 - 1);

  logic [CW-1:0] r_cnt;

  // Free-running bit counter. A clear wins over the wrap. The wrap returns the count to 0 so bit periods chain seamlessly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_mid = (r_cnt == MID);
  assign o_end = (r_cnt == LAST);

endmodule

// File: rtl/uart_rx_deframer.sv
// UART receive deframer. It synchronizes rx and deframes start/data/[parity]/stop.
// Each good byte is delivered into a one-entry valid/ready holding register.
// Framing, parity and overrun errors are reported as single-cycle pulses.
// Define UART_RX_PARITY_EN to add a parity bit between the data and the stop bit.
module uart_rx_deframer
  import uart_pkg::*;
#(
  parameter int BR         = UART_BR_DEFAULT,
  parameter int DATA_WIDTH = UART_DATA_WIDTH_DEFAULT,
  parameter int PARITY_ODD = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_vld,
  input  logic                  rx_rdy,
  output logic                  frame_err,
  output logic                  parity_err,
  output logic                  overrun_err,
  output logic                  busy
);

  localparam int IW = uart_idx_width(DATA_WIDTH);
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

  logic                  r_sync1;
  logic                  r_sync2;
  logic                  r_rxPrev;
  logic [2:0]            r_state;
  logic [IW-1:0]         r_bitIdx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_vld;
  logic                  r_frameErr;
  logic                  r_parityErr;
  logic                  r_overrunErr;

  logic w_fall;
  logic w_mid;
  logic w_end;
  logic w_cntClr;
  logic w_stopSample;
  logic w_parMis;
  logic w_good;

`ifdef UART_RX_PARITY_EN
  logic r_parMis;
  logic w_parExp;
  // Even parity: the parity bit equals the XOR of the data. Odd parity inverts it.
  assign w_parExp = (^r_shift) ^ (PARITY_ODD != 0);
  assign w_parMis = r_parMis;
`else
  logic w_unusedParityOdd;
  assign w_unusedParityOdd = (PARITY_ODD != 0);
  assign w_parMis = 1'b0;
`endif

  // Two-flop synchronizer, plus a history flop for falling-edge detection. All flops idle high like the line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_rxPrev <= 1'b1;
    end else begin
      r_sync1  <= rx;
      r_sync2  <= r_sync1;
      r_rxPrev <= r_sync2;
    end
  end

  assign w_fall = r_rxPrev & ~r_sync2;

  // Hold the counter at 0 while idle. Realign it once the start bit is confirmed, so later samples land mid-bit.
  assign w_cntClr = (r_state == ST_IDLE) || ((r_state == ST_START) && w_mid);

  uart_baud_cnt #(
    .BR (BR)
  ) u_baud (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_cntClr),
    .o_mid (w_mid),
    .o_end (w_end)
  );

  // Frame sequencer. It walks start, data, optional parity and stop, shifting data in LSB first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_bitIdx <= '0;
      r_shift  <= '0;
`ifdef UART_RX_PARITY_EN
      r_parMis <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_fall) begin
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_mid) begin
            if (!r_sync2) begin
              r_state  <= ST_DATA;
              r_bitIdx <= '0;
`ifdef UART_RX_PARITY_EN
              r_parMis <= 1'b0;
`endif
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (w_end) begin
            r_shift[r_bitIdx] <= r_sync2;
            if (r_bitIdx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
              r_state <= ST_PARITY;
`else
              r_state <= ST_STOP;
`endif
            end else begin
              r_bitIdx <= r_bitIdx + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        ST_PARITY: begin
          if (w_end) begin
            r_parMis <= (r_sync2 != w_parExp);
            r_state  <= ST_STOP;
          end
        end
`endif
        ST_STOP: begin
          if (w_end) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign w_stopSample = (r_state == ST_STOP) && w_end;
  assign w_good       = w_stopSample && r_sync2 && !w_parMis;

  // Result stage. It turns the stop-bit verdict into error pulses or a delivery into the holding register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data       <= '0;
      r_vld        <= 1'b0;
      r_frameErr   <= 1'b0;
      r_parityErr  <= 1'b0;
      r_overrunErr <= 1'b0;
    end else begin
      r_frameErr   <= w_stopSample && !r_sync2;
      r_parityErr  <= w_stopSample && r_sync2 && w_parMis;
      r_overrunErr <= 1'b0;
      if (w_good) begin
        if (!r_vld || rx_rdy) begin
          r_data <= r_shift;
          r_vld  <= 1'b1;
        end else begin
          r_overrunErr <= 1'b1;
        end
      end else if (r_vld && rx_rdy) begin
        r_vld <= 1'b0;
      end
    end
  end

  assign rx_data     = r_data;
  assign rx_vld      = r_vld;
  assign frame_err   = r_frameErr;
  assign parity_err  = r_parityErr;
  assign overrun_err = r_overrunErr;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed self-checking bench for uart_rx_deframer.
// It covers basic receive, glitch rejection, framing error, overrun and mid-frame reset.
// When UART_RX_PARITY_EN is defined, it also covers parity.
// Expected bytes go into a scoreboard queue and are checked on each handshake.
module tb_uart_rx_deframer;

  localparam int BR = 434;

  logic       clk;
  logic       rst;
  logic       rx;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic       frame_err;
  logic       parity_err;
  logic       overrun_err;
  logic       busy;

  int         vectors;
  int         miscompares;
  int         cycle;
  int         startCycle;
  int         vldRiseCycle;
  int         vldRiseCnt;
  int         vldHighCnt;
  int         frameCnt;
  int         parityCnt;
  int         overrunCnt;
  logic       prevVld;
  logic [7:0] expQ[$];

  uart_rx_deframer #(
    .BR         (BR),
    .DATA_WIDTH (8),
    .PARITY_ODD (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .rx_data     (rx_data),
    .rx_vld      (rx_vld),
    .rx_rdy      (rx_rdy),
    .frame_err   (frame_err),
    .parity_err  (parity_err),
    .overrun_err (overrun_err),
    .busy        (busy)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter used for latency measurements.
  always @(posedge clk) begin
    cycle = cycle + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors = vectors + 1;
    assert (observed === expected)
    else begin
      miscompares = miscompares + 1;
      $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic clearCounts();
    vldRiseCnt = 0;
    vldHighCnt = 0;
    frameCnt   = 0;
    parityCnt  = 0;
    overrunCnt = 0;
  endtask

  // Drives one full frame, LSB first. The caller must sit just after a posedge.
  // The line is left idle high when the task returns.
  task automatic applyStimulus(input logic [7:0] data, input logic stopBit, input logic parFlip);
    startCycle = cycle;
    rx = 1'b0;
    repeat (BR) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = data[i];
      repeat (BR) @(posedge clk);
      #1;
    end
`ifdef UART_RX_PARITY_EN
    rx = (^data) ^ parFlip;
    repeat (BR) @(posedge clk);
    #1;
`else
    if (parFlip) $display("[TB] parity not compiled in; parity flip request ignored");
`endif
    rx = stopBit;
    repeat (BR) @(posedge clk);
    #1;
    rx = 1'b1;
  endtask

  // Output monitor. It counts pulses and valid rises, and checks each handshaken byte against the scoreboard.
  always @(negedge clk) begin
    if (rst) begin
      prevVld = 1'b0;
    end else begin
      if (rx_vld && !prevVld) begin
        vldRiseCnt   = vldRiseCnt + 1;
        vldRiseCycle = cycle;
      end
      if (rx_vld)      vldHighCnt = vldHighCnt + 1;
      if (frame_err)   frameCnt   = frameCnt + 1;
      if (parity_err)  parityCnt  = parityCnt + 1;
      if (overrun_err) overrunCnt = overrunCnt + 1;
      if (rx_vld && rx_rdy) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_byte_qsize", 32'(expQ.size()), 32'd1);
        end else begin
          checkOutput("rx_data", {24'd0, rx_data}, {24'd0, expQ.pop_front()});
        end
      end
      prevVld = rx_vld;
    end
  end

  // Absolute time limit so the run always ends.
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    vectors     = 0;
    miscompares = 0;
    cycle       = 0;
    prevVld     = 1'b0;
    rst         = 1'b1;
    rx          = 1'b1;
    rx_rdy      = 1'b0;
    clearCounts();

    repeat (4) @(posedge clk);
    #1;
    checkOutput("reset_rx_vld", rx_vld, 0);
    checkOutput("reset_rx_data", rx_data, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_errs", {frame_err, parity_err, overrun_err}, 0);
    rst = 1'b0;
    repeat (10) @(posedge clk);
    #1;

    $display("[TB] basic receive 0xA5");
    rx_rdy = 1'b1;
    clearCounts();
    expQ.push_back(8'hA5);
    applyStimulus(8'hA5, 1'b1, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    checkOutput("basic_delivered", 32'(expQ.size()), 0);
    checkOutput("basic_vld_rises", vldRiseCnt, 1);
    checkOutput("basic_vld_width", vldHighCnt, 1);
    checkOutput("basic_no_errs", frameCnt + parityCnt + overrunCnt, 0);
    // Nominal delivery is 4125 cycles after the start edge. rx changes just after an edge, so the
    // DUT first sees it one edge later. That adds 1 to the measured value, so the window is 4126 +/- 1.
    checkOutput("basic_latency_window",
                32'((vldRiseCycle - startCycle >= 4125) && (vldRiseCycle - startCycle <= 4127)), 1);

    $display("[TB] glitch rejection");
    clearCounts();
    rx = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    checkOutput("glitch_busy_during", busy, 1);
    rx = 1'b1;
    repeat (150) @(posedge clk);
    #1;
    checkOutput("glitch_busy_after", busy, 0);
    checkOutput("glitch_no_vld", vldRiseCnt, 0);
    checkOutput("glitch_no_errs", frameCnt + parityCnt + overrunCnt, 0);

    $display("[TB] framing error then recovery");
    clearCounts();
    applyStimulus(8'h3C, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("ferr_pulses", frameCnt, 1);
    checkOutput("ferr_no_vld", vldRiseCnt, 0);
    checkOutput("ferr_no_other_errs", parityCnt + overrunCnt, 0);
    repeat (2 * BR) @(posedge clk);
    #1;
    clearCounts();
    expQ.push_back(8'h55);
    applyStimulus(8'h55, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("ferr_recover_delivered", 32'(expQ.size()), 0);
    checkOutput("ferr_recover_vld_rises", vldRiseCnt, 1);
    checkOutput("ferr_recover_no_errs", frameCnt + parityCnt + overrunCnt, 0);

    $display("[TB] overrun");
    repeat (20) @(posedge clk);
    #1;
    rx_rdy = 1'b0;
    clearCounts();
    expQ.push_back(8'h11);
    applyStimulus(8'h11, 1'b1, 1'b0);
    applyStimulus(8'h22, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("ovr_pulses", overrunCnt, 1);
    checkOutput("ovr_data_held", rx_data, 8'h11);
    checkOutput("ovr_vld_held", rx_vld, 1);
    checkOutput("ovr_vld_rises", vldRiseCnt, 1);
    rx_rdy = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("ovr_vld_drop", rx_vld, 0);
    checkOutput("ovr_drained", 32'(expQ.size()), 0);

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity good and bad");
    repeat (20) @(posedge clk);
    #1;
    clearCounts();
    expQ.push_back(8'h03);
    applyStimulus(8'h03, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("par_good_delivered", 32'(expQ.size()), 0);
    checkOutput("par_good_no_perr", parityCnt, 0);
    clearCounts();
    applyStimulus(8'h03, 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("par_bad_perr", parityCnt, 1);
    checkOutput("par_bad_no_vld", vldRiseCnt, 0);
    checkOutput("par_bad_no_ferr", frameCnt, 0);
`endif

    $display("[TB] reset mid-frame");
    repeat (20) @(posedge clk);
    #1;
    rx_rdy = 1'b0;
    clearCounts();
    applyStimulus(8'h5A, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("rst_pre_data", rx_data, 8'h5A);
    checkOutput("rst_pre_vld", rx_vld, 1);
    fork
      applyStimulus(8'hFF, 1'b1, 1'b0);
      begin
        repeat (5 * BR + BR / 2) @(posedge clk);
        #1;
        checkOutput("rst_pre_busy", busy, 1);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst_async_vld", rx_vld, 0);
        checkOutput("rst_async_data", rx_data, 0);
        checkOutput("rst_async_busy", busy, 0);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b0;
      end
    join
    repeat (20) @(posedge clk);
    #1;
    checkOutput("rst_no_spurious", vldRiseCnt + frameCnt, 1);
    rx_rdy = 1'b1;
    clearCounts();
    expQ.push_back(8'h81);
    applyStimulus(8'h81, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("rst_next_delivered", 32'(expQ.size()), 0);
    checkOutput("rst_next_vld_rises", vldRiseCnt, 1);
    checkOutput("rst_next_no_errs", frameCnt + parityCnt + overrunCnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
